inert_fusion: RTL and testbench
===============================

# inert_fusion

Rate-to-angle engine that consumes the gyro rates and accelerations assembled by the inertial sensor interface and produces fused pitch, roll and yaw angles for the flight controller. It performs a gyro-offset calibration on command, then integrates the offset-corrected rates on every new sample. Pitch and roll are pulled toward the accelerometer-derived angle by a fixed complementary-fusion step. It sits directly downstream of the SPI holding registers and upstream of the flight controller.

## Interface
- FAST_SIM, 1, selects calibration length: CAL_SHIFT = 8 (256 samples) when 1, 11 (2048 samples) when 0
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- strt_cal  in  1  one-cycle pulse from command config; starts calibration
- vld  in  1  one-cycle pulse; rate/accel inputs are valid this cycle
- ptch_rt, roll_rt, yaw_rt  in  16 signed  raw gyro rates
- ax, ay  in  16 signed  accel-derived roll and pitch references
- ptch, roll, yaw  out  16 signed  fused angles, registered
- ang_vld  out  1  one-cycle pulse; angles updated
- cal_done  out  1  one-cycle pulse when calibration completes

## Operation
- States: IDLE, CAL, RUN. Reset enters IDLE.
- IDLE: vld is ignored and outputs are held. strt_cal moves to CAL.
- strt_cal in any state:
  - clears the three 27-bit accumulators and the 11-bit sample counter
  - enters CAL
  - has priority over a coincident vld; that sample is discarded.
- CAL, per vld:
  - each accumulator adds its sign-extended rate
  - the counter increments.
  - On the vld where counter == 2^CAL_SHIFT-1:
    - offsets load acc >>> CAL_SHIFT (arithmetic shift, includes the current sample)
    - the three angle integrators clear to 0
    - cal_done pulses next cycle
    - state becomes RUN.
  - No ang_vld is issued in CAL.
- RUN, per vld:
  - comp = rt − offset, computed in 17 bits, then saturated to 16 bits (±32767/−32768).
  - Integrators are 27-bit signed. Angle output = integ[26:11].
  - Pitch: integ += sext(comp) + F, where F = +FUSION if ptch < ay, −FUSION if ptch > ay, 0 if equal. ptch is the current registered output.
  - Roll: same rule using roll and ax.
  - Yaw: integ += sext(comp), with no fusion term.
  - Integrators wrap modulo 2^27; there is no saturation.
  - ang_vld pulses the cycle after vld.
- Reset mid-operation:
  - all registers clear and the state returns to IDLE
  - offsets return to 0
  - outputs, ang_vld and cal_done return to 0.

## Timing
- Reset values: ptch = roll = yaw = 0, ang_vld = 0, cal_done = 0. Offsets, accumulators and counter are all 0.
- RUN latency:
  - vld at cycle N updates the integrators at edge N+1
  - ptch/roll/yaw are new and ang_vld = 1 in cycle N+1.
- Calibration: cal_done is high for exactly the one cycle after the final calibration vld.
- Back-to-back vld (every cycle) is supported in both CAL and RUN with no lost samples.
- strt_cal with vld in the same cycle: CAL starts and the counter stays 0.
- strt_cal during RUN:
  - outputs hold their last values until the next calibration completes
  - ang_vld is suppressed.

## Structure
- Shared package (inert_pkg) holds:
  - state enum {IDLE, CAL, RUN}
  - FUSION = 512
  - ACC_W = 27, INT_W = 27
  - CAL_SHIFT function of FAST_SIM.
- One sub-module, axis_integ, instantiated three times with a fusion-enable parameter (0 for yaw). It contains:
  - the offset register and calibration accumulator
  - the saturating subtract
  - the integrator and the fusion compare.
- The top level holds the FSM, the sample counter and the ang_vld/cal_done pulse generation.

## Test plan
- Calibration averaging: FAST_SIM = 1, strt_cal, then 256 vld with ptch_rt = 100, roll_rt = −40, yaw_rt = 7.
  - cal_done pulses once, one cycle after the 256th vld.
  - Then vld with the same rates and ax = ay = 0 → ptch = roll = yaw = 0 and ang_vld pulses each time.
- Integration with fusion saturating high: calibrate on zeros, then 4 vld with ptch_rt = 2048, ay = 0x7FFF.
  - Integrator reaches 4×2560 = 10240 → ptch = 5.
  - yaw_rt = −2048 for 3 vld → yaw = −3.
- Fusion convergence: calibrate on zeros, rates 0, ay = 100.
  - ptch = 1 after 4 vld and reaches 100 after 400 vld.
  - Thereafter it alternates 99/100 or holds 100; it never exceeds 100.
- Saturation: calibrate with ptch_rt = −100, then ptch_rt = 0x7FFF.
  - comp clamps to 32767; the integrator grows by 32767 plus fusion per vld.
- strt_cal coincident with vld during RUN:
  - that sample is discarded and ang_vld is suppressed
  - cal_done arrives only after a further 256 vld
  - outputs hold in the meantime.
- rst_n asserted mid-CAL at sample 100:
  - all outputs are 0 and the state is IDLE
  - later vld with no strt_cal gives no ang_vld.

Source files
------------

// File: rtl/inert_fusion_pkg.sv
// Shared types and constants for the rate-to-angle fusion engine.
// CAL_SHIFT is derived from FAST_SIM so simulation can calibrate on 256 samples.
package inert_pkg;

   typedef enum logic [1:0] {IDLE, CAL, RUN} state_t;

   localparam int FUSION = 512;
   localparam int ACC_W  = 27;
   localparam int INT_W  = 27;
   localparam int ANG_W  = 16;
   localparam int CNT_W  = 11;

   function automatic int cal_shift(input int fast_sim);
      return (fast_sim != 0) ? 8 : 11;
   endfunction

endpackage

// File: rtl/inert_fusion_axis_integ.sv
// One axis: gyro offset calibration, offset-corrected saturating rate,
// 27-bit wrapping integrator with an optional complementary-fusion nudge.
module axis_integ
   import inert_pkg::*;
#(
   parameter bit FUSE_EN   = 1'b1,
   parameter int CAL_SHIFT = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clr_i,
   input  logic                    cal_smp_i,
   input  logic                    cal_fin_i,
   input  logic                    run_smp_i,
   input  logic signed [ANG_W-1:0] rt_i,
   input  logic signed [ANG_W-1:0] ref_i,
   output logic signed [ANG_W-1:0] ang_o
);

   localparam logic signed [INT_W-1:0] FUSE_P = INT_W'(FUSION);

   logic signed [ACC_W-1:0] acc_q, acc_d, acc_sum;
   logic signed [ANG_W-1:0] off_q, off_d;
   logic signed [INT_W-1:0] integ_q, integ_d, fuse;
   logic signed [ANG_W-1:0] comp;

   function automatic logic signed [ANG_W-1:0] sat16(input logic signed [ANG_W:0] v);
      if (v > 17'sd32767)
         return 16'sh7FFF;
      else if (v < -17'sd32768)
         return 16'sh8000;
      return v[ANG_W-1:0];
   endfunction

   assign ang_o   = integ_q[INT_W-1 -: ANG_W];
   assign acc_sum = acc_q + ACC_W'(rt_i);
   assign comp    = sat16(17'(rt_i) - 17'(off_q));

   always_comb begin
      fuse = '0;
      if (FUSE_EN) begin
         if (ang_o < ref_i)
            fuse = FUSE_P;
         else if (ang_o > ref_i)
            fuse = -FUSE_P;
      end
   end

   // The final calibration sample is included in the average.
   always_comb begin
      acc_d   = acc_q;
      off_d   = off_q;
      integ_d = integ_q;
      if (clr_i)
         acc_d = '0;
      else if (cal_smp_i)
         acc_d = acc_sum;
      if (cal_fin_i) begin
         off_d   = ANG_W'(acc_sum >>> CAL_SHIFT);
         integ_d = '0;
      end else if (run_smp_i) begin
         integ_d = integ_q + INT_W'(comp) + fuse;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q   <= '0;
         off_q   <= '0;
         integ_q <= '0;
      end else begin
         acc_q   <= acc_d;
         off_q   <= off_d;
         integ_q <= integ_d;
      end
   end

endmodule

// File: rtl/inert_fusion.sv
// Top: IDLE/CAL/RUN sequencing, calibration sample counter and the
// ang_vld / cal_done pulses around three per-axis integrators.
module inert_fusion
   import inert_pkg::*;
#(
   parameter int FAST_SIM = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    strt_cal,
   input  logic                    vld,
   input  logic signed [ANG_W-1:0] ptch_rt,
   input  logic signed [ANG_W-1:0] roll_rt,
   input  logic signed [ANG_W-1:0] yaw_rt,
   input  logic signed [ANG_W-1:0] ax,
   input  logic signed [ANG_W-1:0] ay,
   output logic signed [ANG_W-1:0] ptch,
   output logic signed [ANG_W-1:0] roll,
   output logic signed [ANG_W-1:0] yaw,
   output logic                    ang_vld,
   output logic                    cal_done
);

   localparam int CAL_SHIFT = cal_shift(FAST_SIM);
   localparam logic [CNT_W-1:0] CAL_LAST = CNT_W'((1 << CAL_SHIFT) - 1);

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             ang_vld_q, cal_done_q;
   logic             cal_smp, cal_fin, run_smp;

   // strt_cal outranks a coincident vld, so that sample never reaches an axis.
   assign cal_smp = vld && !strt_cal && (state_q == CAL);
   assign cal_fin = cal_smp && (cnt_q == CAL_LAST);
   assign run_smp = vld && !strt_cal && (state_q == RUN);

   assign ang_vld  = ang_vld_q;
   assign cal_done = cal_done_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         ang_vld_q  <= 1'b0;
         cal_done_q <= 1'b0;
      end else begin
         ang_vld_q  <= run_smp;
         cal_done_q <= cal_fin;
         if (strt_cal) begin
            state_q <= CAL;
            cnt_q   <= '0;
         end else begin
            case (state_q)
               CAL: begin
                  if (cal_fin) begin
                     state_q <= RUN;
                     cnt_q   <= '0;
                  end else if (cal_smp) begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   axis_integ #(.FUSE_EN(1'b1), .CAL_SHIFT(CAL_SHIFT)) u_ptch (
      .clk(clk), .rst_n(rst_n), .clr_i(strt_cal), .cal_smp_i(cal_smp),
      .cal_fin_i(cal_fin), .run_smp_i(run_smp), .rt_i(ptch_rt), .ref_i(ay),
      .ang_o(ptch)
   );

   axis_integ #(.FUSE_EN(1'b1), .CAL_SHIFT(CAL_SHIFT)) u_roll (
      .clk(clk), .rst_n(rst_n), .clr_i(strt_cal), .cal_smp_i(cal_smp),
      .cal_fin_i(cal_fin), .run_smp_i(run_smp), .rt_i(roll_rt), .ref_i(ax),
      .ang_o(roll)
   );

   axis_integ #(.FUSE_EN(1'b0), .CAL_SHIFT(CAL_SHIFT)) u_yaw (
      .clk(clk), .rst_n(rst_n), .clr_i(strt_cal), .cal_smp_i(cal_smp),
      .cal_fin_i(cal_fin), .run_smp_i(run_smp), .rt_i(yaw_rt), .ref_i(16'sd0),
      .ang_o(yaw)
   );

endmodule

// File: tb/tb_inert_fusion.sv
// Self-checking bench for inert_fusion (FAST_SIM=1) against an arithmetic
// reference model of calibration, saturation, fusion and integration.
module tb_inert_fusion;

   localparam int     CAL_N  = 256;
   localparam int     CAL_SH = 8;
   localparam longint MOD27  = 64'sd134217728;

   logic               clk = 1'b0;
   logic               rst_n, strt_cal, vld;
   logic signed [15:0] ptch_rt, roll_rt, yaw_rt, ax, ay;
   logic signed [15:0] ptch, roll, yaw;
   logic               ang_vld, cal_done;
   logic [49:0]        dut_vec;

   int n_cmp = 0;
   int n_bad = 0;

   int     m_mode;
   int     m_cnt;
   longint m_sum [3];
   int     m_off [3];
   longint m_int [3];
   bit     m_angv, m_cdone;

   inert_fusion #(.FAST_SIM(1)) dut (
      .clk(clk), .rst_n(rst_n), .strt_cal(strt_cal), .vld(vld),
      .ptch_rt(ptch_rt), .roll_rt(roll_rt), .yaw_rt(yaw_rt), .ax(ax), .ay(ay),
      .ptch(ptch), .roll(roll), .yaw(yaw), .ang_vld(ang_vld), .cal_done(cal_done)
   );

   always #5 clk = ~clk;

   assign dut_vec = {ptch, roll, yaw, ang_vld, cal_done};

   function automatic logic signed [15:0] m_ang(input longint i);
      longint w;
      w = ((i % MOD27) + MOD27) % MOD27;
      if (w >= MOD27 / 2) w = w - MOD27;
      return 16'(w >>> 11);
   endfunction

   function automatic logic [49:0] exp_vec();
      return {m_ang(m_int[0]), m_ang(m_int[1]), m_ang(m_int[2]), m_angv, m_cdone};
   endfunction

   function automatic int rnd16();
      logic signed [15:0] r;
      r = 16'($urandom);
      return int'(r);
   endfunction

   task automatic model_reset();
      m_mode = 0;
      m_cnt  = 0;
      for (int a = 0; a < 3; a++) begin
         m_sum[a] = 0;
         m_off[a] = 0;
         m_int[a] = 0;
      end
      m_angv  = 0;
      m_cdone = 0;
   endtask

   // Apply one cycle of inputs, advance the model, return #1 after the edge.
   task automatic drive(input bit s, input bit v, input int pr, input int rr,
                        input int yr, input int xa, input int ya);
      int     rt [3];
      int     rf [2];
      longint c, f;
      int     cur;
      strt_cal = s;
      vld      = v;
      ptch_rt  = 16'(pr);
      roll_rt  = 16'(rr);
      yaw_rt   = 16'(yr);
      ax       = 16'(xa);
      ay       = 16'(ya);
      rt[0] = pr; rt[1] = rr; rt[2] = yr;
      rf[0] = ya; rf[1] = xa;
      m_angv  = 0;
      m_cdone = 0;
      if (s) begin
         m_mode = 1;
         m_cnt  = 0;
         for (int a = 0; a < 3; a++) m_sum[a] = 0;
      end else if (v && m_mode == 1) begin
         for (int a = 0; a < 3; a++) m_sum[a] += rt[a];
         m_cnt++;
         if (m_cnt == CAL_N) begin
            for (int a = 0; a < 3; a++) begin
               m_off[a] = int'(m_sum[a] >>> CAL_SH);
               m_int[a] = 0;
            end
            m_cdone = 1;
            m_mode  = 2;
         end
      end else if (v && m_mode == 2) begin
         for (int a = 0; a < 3; a++) begin
            c = rt[a] - m_off[a];
            if (c > 32767) c = 32767;
            if (c < -32768) c = -32768;
            f = 0;
            if (a < 2) begin
               cur = int'(m_ang(m_int[a]));
               if (cur < rf[a]) f = 512;
               else if (cur > rf[a]) f = -512;
            end
            m_int[a] += c + f;
         end
         m_angv = 1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic calibrate(input int pr, input int rr, input int yr);
      drive(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < CAL_N; i++) drive(0, 1, pr, rr, yr, 0, 0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; strt_cal = 1'b0; vld = 1'b0;
      ptch_rt = '0; roll_rt = '0; yaw_rt = '0; ax = '0; ay = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (ptch !== 16'sd0) begin n_bad++; $display("FAIL reset_ptch got=%0d exp=0", ptch); end
      n_cmp++; if (roll !== 16'sd0) begin n_bad++; $display("FAIL reset_roll got=%0d exp=0", roll); end
      n_cmp++; if (yaw !== 16'sd0) begin n_bad++; $display("FAIL reset_yaw got=%0d exp=0", yaw); end
      n_cmp++; if (ang_vld !== 1'b0) begin n_bad++; $display("FAIL reset_ang_vld got=%b exp=0", ang_vld); end
      n_cmp++; if (cal_done !== 1'b0) begin n_bad++; $display("FAIL reset_cal_done got=%b exp=0", cal_done); end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 500, 500, 500, 0, 0);
         n_cmp++;
         if (dut_vec !== exp_vec()) begin
            n_bad++; $display("FAIL idle_ignores_vld got=%h exp=%h", dut_vec, exp_vec());
         end
      end
   endtask

   task automatic test_cal_avg();
      int pulses = 0;
      drive(1, 1, 100, -40, 7, 0, 0);
      for (int i = 1; i <= CAL_N; i++) begin
         drive(0, 1, 100, -40, 7, 0, 0);
         if (cal_done) pulses++;
         n_cmp++;
         if (dut_vec !== exp_vec()) begin
            n_bad++; $display("FAIL cal_avg smp=%0d got=%h exp=%h", i, dut_vec, exp_vec());
         end
      end
      n_cmp++;
      if (cal_done !== 1'b1) begin n_bad++; $display("FAIL cal_done_timing got=%b exp=1", cal_done); end
      for (int i = 0; i < 5; i++) begin
         drive(0, 1, 100, -40, 7, 0, 0);
         if (cal_done) pulses++;
         n_cmp++;
         if ({ptch, roll, yaw, ang_vld} !== {16'sd0, 16'sd0, 16'sd0, 1'b1}) begin
            n_bad++; $display("FAIL cal_avg_zero got=%0d/%0d/%0d vld=%b exp=0/0/0 vld=1", ptch, roll, yaw, ang_vld);
         end
      end
      n_cmp++;
      if (pulses !== 1) begin n_bad++; $display("FAIL cal_done_count got=%0d exp=1", pulses); end
   endtask

   task automatic test_integ_fusion();
      calibrate(0, 0, 0);
      for (int i = 0; i < 4; i++) drive(0, 1, 2048, 0, 0, 0, 32767);
      n_cmp++;
      if (ptch !== 16'sd5) begin n_bad++; $display("FAIL fusion_high_ptch got=%0d exp=5", ptch); end
      n_cmp++;
      if (dut_vec !== exp_vec()) begin n_bad++; $display("FAIL fusion_high_vec got=%h exp=%h", dut_vec, exp_vec()); end
      for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, -2048, 0, 32767);
      n_cmp++;
      if (yaw !== -16'sd3) begin n_bad++; $display("FAIL yaw_integ got=%0d exp=-3", yaw); end
      n_cmp++;
      if (dut_vec !== exp_vec()) begin n_bad++; $display("FAIL yaw_integ_vec got=%h exp=%h", dut_vec, exp_vec()); end
   endtask

   task automatic test_convergence();
      calibrate(0, 0, 0);
      for (int i = 1; i <= 460; i++) begin
         drive(0, 1, 0, 0, 0, 0, 100);
         if (i == 4) begin
            n_cmp++;
            if (ptch !== 16'sd1) begin n_bad++; $display("FAIL conv_4 got=%0d exp=1", ptch); end
         end
         if (i == 400) begin
            n_cmp++;
            if (ptch !== 16'sd100) begin n_bad++; $display("FAIL conv_400 got=%0d exp=100", ptch); end
         end
         if (i > 400) begin
            n_cmp++;
            if (ptch > 16'sd100 || ptch < 16'sd99) begin
               n_bad++; $display("FAIL conv_hold i=%0d got=%0d exp=99..100", i, ptch);
            end
         end
         n_cmp++;
         if (dut_vec !== exp_vec()) begin
            n_bad++; $display("FAIL conv_vec i=%0d got=%h exp=%h", i, dut_vec, exp_vec());
         end
      end
   endtask

   task automatic test_saturation();
      calibrate(-100, 0, 100);
      drive(0, 1, 32767, 0, -32768, 0, 0);
      n_cmp++;
      if (ptch !== 16'sd15) begin n_bad++; $display("FAIL sat_high got=%0d exp=15", ptch); end
      n_cmp++;
      if (yaw !== -16'sd16) begin n_bad++; $display("FAIL sat_low got=%0d exp=-16", yaw); end
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 32767, 0, -32768, 0, 0);
         n_cmp++;
         if (dut_vec !== exp_vec()) begin
            n_bad++; $display("FAIL sat_vec i=%0d got=%h exp=%h", i, dut_vec, exp_vec());
         end
      end
   endtask

   task automatic test_back_to_back();
      calibrate($urandom_range(0, 2000) - 1000, $urandom_range(0, 2000) - 1000,
                $urandom_range(0, 2000) - 1000);
      for (int i = 0; i < 300; i++) begin
         drive(0, ($urandom_range(0, 3) != 0), rnd16(), rnd16(), rnd16(), rnd16(), rnd16());
         n_cmp++;
         if (dut_vec !== exp_vec()) begin
            n_bad++; $display("FAIL random_run i=%0d got=%h exp=%h", i, dut_vec, exp_vec());
         end
      end
   endtask

   task automatic test_strt_during_run();
      logic [47:0] held;
      for (int i = 0; i < 4; i++) drive(0, 1, 3000, -3000, 1500, 0, 0);
      held = exp_vec() >> 2;
      drive(1, 1, rnd16(), rnd16(), rnd16(), rnd16(), rnd16());
      n_cmp++;
      if ({ptch, roll, yaw, ang_vld} !== {held, 1'b0}) begin
         n_bad++; $display("FAIL strt_vld_discard got=%h exp=%h", {ptch, roll, yaw, ang_vld}, {held, 1'b0});
      end
      for (int i = 1; i <= CAL_N; i++) begin
         drive(0, 1, rnd16(), rnd16(), rnd16(), rnd16(), rnd16());
         if (i < CAL_N) begin
            n_cmp++;
            if ({ptch, roll, yaw, ang_vld, cal_done} !== {held, 2'b00}) begin
               n_bad++; $display("FAIL recal_hold i=%0d got=%h exp=%h", i, dut_vec, {held, 2'b00});
            end
         end
      end
      n_cmp++;
      if (cal_done !== 1'b1) begin n_bad++; $display("FAIL recal_done got=%b exp=1", cal_done); end
      n_cmp++;
      if (dut_vec !== exp_vec()) begin n_bad++; $display("FAIL recal_vec got=%h exp=%h", dut_vec, exp_vec()); end
   endtask

   task automatic test_reset_midcal();
      for (int i = 0; i < 5; i++) drive(0, 1, 4000, -4000, 2048, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 100; i++) drive(0, 1, rnd16(), rnd16(), rnd16(), 0, 0);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin n_bad++; $display("FAIL midcal_hold got=%h exp=%h", dut_vec, exp_vec()); end
      rst_n = 1'b0;
      model_reset();
      #2;
      n_cmp++;
      if (dut_vec !== 50'd0) begin n_bad++; $display("FAIL midcal_reset got=%h exp=0", dut_vec); end
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive(0, 1, rnd16(), rnd16(), rnd16(), rnd16(), rnd16());
         n_cmp++;
         if (dut_vec !== 50'd0) begin
            n_bad++; $display("FAIL post_reset_idle i=%0d got=%h exp=0", i, dut_vec);
         end
      end
   endtask

   initial begin
      test_reset();
      test_cal_avg();
      test_integ_fusion();
      test_convergence();
      test_saturation();
      test_back_to_back();
      test_strt_during_run();
      test_reset_midcal();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
